// File: rtl/wspr_pkg.sv
// Shared constants and state encoding for the WSPR 4-FSK symbol sequencer.
package wspr_pkg;

  localparam int WSPR_FW           = 32;
  localparam int WSPR_AW           = 8;
  localparam int WSPR_N_SYMBOLS    = 162;
  localparam int WSPR_SYMBOL_TICKS = 52428800;
  localparam int WSPR_TONE_STEP    = 82;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN,
    DONE
  } wspr_state_t;

endpackage

// File: rtl/wspr_symbol_ram.sv
// 2-bit wide symbol store: one synchronous write port, one registered read port.
module wspr_symbol_ram #(
  parameter int AW    = 8,
  parameter int DEPTH = 162
) (
  input  logic          clock,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [1:0]    wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [1:0]    rd_data
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [1:0] mem [DEPTH];

  // Addresses are range-checked by the caller, so only the low IW bits matter.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr[IW-1:0]] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr[IW-1:0]];
  end

endmodule

// File: rtl/wspr_symbol_sequencer.sv
// Steps the NCO frequency word through a preloaded WSPR symbol sequence with cycle-exact symbol timing.
module wspr_symbol_sequencer
  import wspr_pkg::*;
#(
  parameter int FW           = WSPR_FW,
  parameter int AW           = WSPR_AW,
  parameter int N_SYMBOLS    = WSPR_N_SYMBOLS,
  parameter int SYMBOL_TICKS = WSPR_SYMBOL_TICKS,
  parameter int TONE_STEP    = WSPR_TONE_STEP
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic signed [FW-1:0] base_freq,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [1:0]           wr_data,
  output logic                 wr_err,
  input  logic                 start,
  input  logic                 abort,
  output logic signed [FW-1:0] frequency,
  output logic                 tx_active,
  output logic [AW-1:0]        symbol_index,
  output logic                 done
);

  localparam int            TW        = (SYMBOL_TICKS > 2) ? $clog2(SYMBOL_TICKS) : 2;
  localparam logic [TW-1:0] TICK_PRE  = TW'(SYMBOL_TICKS - 2);
  localparam logic [TW-1:0] TICK_LAST = TW'(SYMBOL_TICKS - 1);
  localparam logic [AW-1:0] LAST_IDX  = AW'(N_SYMBOLS - 1);

  wspr_state_t          state, state_nx;
  logic [TW-1:0]        tick, tick_nx;
  logic [AW-1:0]        idx_nx;
  logic signed [FW-1:0] freq_nx;
  logic signed [FW-1:0] base_q;
  logic                 tx_nx, done_nx, load_base;
  logic                 rd_en;
  logic [AW-1:0]        rd_addr;
  logic [1:0]           sym_p1;
  logic                 wr_ok;

  // Tone product never exceeds 3*TONE_STEP; the sum wraps modulo 2^FW like NCO phase.
  function automatic logic signed [FW-1:0] tone_word(input logic signed [FW-1:0] base,
                                                     input logic [1:0]           sym);
    logic signed [FW-1:0] prod;
    prod = $signed(FW'(sym) * FW'(TONE_STEP));
    return base + prod;
  endfunction

  assign wr_ok = wr_en && (state == IDLE) && (wr_addr <= LAST_IDX);

  wspr_symbol_ram #(
    .AW   (AW),
    .DEPTH(N_SYMBOLS)
  ) u_ram (
    .clock  (clock),
    .wr_en  (wr_ok),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_en  (rd_en),
    .rd_addr(rd_addr),
    .rd_data(sym_p1)
  );

  always_comb begin
    state_nx  = state;
    tick_nx   = tick;
    idx_nx    = symbol_index;
    freq_nx   = frequency;
    tx_nx     = tx_active;
    done_nx   = 1'b0;
    load_base = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = '0;
    case (state)
      IDLE: begin
        freq_nx = base_freq;
        if (start && !abort) begin
          state_nx  = PRIME;
          load_base = 1'b1;
          rd_en     = 1'b1;
        end
      end
      PRIME: begin
        if (abort) begin
          state_nx = IDLE;
          freq_nx  = base_freq;
        end else begin
          state_nx = RUN;
          freq_nx  = tone_word(base_q, sym_p1);
          tx_nx    = 1'b1;
          idx_nx   = '0;
          tick_nx  = '0;
        end
      end
      RUN: begin
        if (abort) begin
          state_nx = IDLE;
          freq_nx  = base_freq;
          tx_nx    = 1'b0;
          idx_nx   = '0;
          tick_nx  = '0;
        end else begin
          tick_nx = tick + 1'b1;
          // Prefetch one cycle early so the next tone lands on the symbol boundary.
          if (tick == TICK_PRE && symbol_index < LAST_IDX) begin
            rd_en   = 1'b1;
            rd_addr = symbol_index + 1'b1;
          end
          if (tick == TICK_LAST) begin
            tick_nx = '0;
            if (symbol_index < LAST_IDX) begin
              idx_nx  = symbol_index + 1'b1;
              freq_nx = tone_word(base_q, sym_p1);
            end else begin
              state_nx = DONE;
              freq_nx  = base_freq;
              tx_nx    = 1'b0;
              idx_nx   = '0;
              done_nx  = 1'b1;
            end
          end
        end
      end
      DONE: begin
        state_nx = IDLE;
        freq_nx  = base_freq;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      tick         <= '0;
      symbol_index <= '0;
      frequency    <= '0;
      tx_active    <= 1'b0;
      done         <= 1'b0;
      wr_err       <= 1'b0;
    end else begin
      state        <= state_nx;
      tick         <= tick_nx;
      symbol_index <= idx_nx;
      frequency    <= freq_nx;
      tx_active    <= tx_nx;
      done         <= done_nx;
      wr_err       <= wr_err | (wr_en & ~wr_ok);
    end
  end

  // Base word is pure data, captured only when a transmission starts.
  always_ff @(posedge clock) begin
    if (load_base) base_q <= base_freq;
  end

endmodule

// File: tb/tb_wspr_symbol_sequencer.sv
// Directed and randomized bench for wspr_symbol_sequencer with a per-cycle tone schedule model.
module tb_wspr_symbol_sequencer;

  localparam int N  = 4;
  localparam int ST = 8;
  localparam int TS = 82;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] base_freq;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [1:0]  wr_data;
  logic        wr_err;
  logic        start;
  logic        abort;
  logic [31:0] frequency;
  logic        tx_active;
  logic [7:0]  symbol_index;
  logic        done;

  logic [1:0]  model [N];
  int          errors = 0;
  int          checks = 0;

  wspr_symbol_sequencer #(
    .FW(32), .AW(8), .N_SYMBOLS(N), .SYMBOL_TICKS(ST), .TONE_STEP(TS)
  ) dut (
    .clock(clock), .reset_n(reset_n), .base_freq(base_freq),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err),
    .start(start), .abort(abort), .frequency(frequency),
    .tx_active(tx_active), .symbol_index(symbol_index), .done(done)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic write_sym(input logic [7:0] addr, input logic [1:0] data);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = data;
    step();
    wr_en   = 1'b0;
  endtask

  // Expected frequency for on-air cycle k: latched base plus the k/ST-th tone times the step.
  task automatic run_full(input logic [31:0] base, input bit change_base,
                          input bit wr_during, input int abort_at);
    logic [31:0] exp_f;
    base_freq = base;
    start = 1'b1;
    step();
    start = 1'b0;
    check("prime_tx", tx_active, 0);
    step();
    for (int k = 0; k < N * ST; k++) begin
      exp_f = base + 32'(model[k / ST]) * 32'(TS);
      check("tx", tx_active, 1);
      check("freq", frequency, exp_f);
      check("idx", symbol_index, k / ST);
      check("done_low", done, 0);
      if (k == abort_at) begin
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("ab_tx", tx_active, 0);
        check("ab_idx", symbol_index, 0);
        check("ab_freq", frequency, base_freq);
        for (int j = 0; j < ST + 2; j++) begin
          check("ab_done", done, 0);
          check("ab_idle_tx", tx_active, 0);
          step();
        end
        return;
      end
      if (change_base && k == ST + 3) base_freq = $urandom;
      if (wr_during && k == 3) begin
        wr_en   = 1'b1;
        wr_addr = 8'd1;
        wr_data = ~model[1];
      end
      step();
      wr_en = 1'b0;
    end
    check("end_tx", tx_active, 0);
    check("end_done", done, 1);
    check("end_idx", symbol_index, 0);
    step();
    check("done_pulse", done, 0);
    check("idle_tx", tx_active, 0);
    step();
    check("track", frequency, base_freq);
  endtask

  initial begin
    reset_n   = 1'b0;
    base_freq = 32'd0;
    wr_en     = 1'b0;
    wr_addr   = 8'd0;
    wr_data   = 2'd0;
    start     = 1'b0;
    abort     = 1'b0;
    #1;
    check("rst_freq", frequency, 0);
    check("rst_tx", tx_active, 0);
    check("rst_idx", symbol_index, 0);
    check("rst_done", done, 0);
    check("rst_wr_err", wr_err, 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    step();

    model[0] = 2'd0; model[1] = 2'd3; model[2] = 2'd1; model[3] = 2'd2;
    for (int i = 0; i < N; i++) write_sym(8'(i), model[i]);
    check("wr_err_clean", wr_err, 0);

    base_freq = 32'd1234;
    step();
    step();
    check("idle_track", frequency, 32'd1234);

    // Normal run with base change mid-run.
    run_full(32'd1000, 1'b1, 1'b0, -1);

    // Out-of-range write in IDLE.
    write_sym(8'd4, 2'd3);
    check("wr_err_addr", wr_err, 1);
    run_full(32'd1000, 1'b0, 1'b0, -1);

    // start and abort together: must stay idle.
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    check("sa_tx1", tx_active, 0);
    step();
    check("sa_tx2", tx_active, 0);
    step();
    check("sa_tx3", tx_active, 0);

    // Abort at tick 5 of symbol 2.
    run_full(32'd2000, 1'b0, 1'b0, 2 * ST + 5);

    // Write during RUN is dropped; later run replays originals.
    run_full(32'd500, 1'b0, 1'b1, -1);
    check("wr_err_run", wr_err, 1);
    run_full(32'd700, 1'b0, 1'b0, -1);

    // Wrap-around with symbol 3 at index 0.
    model[0] = 2'd3;
    write_sym(8'd0, 2'd3);
    base_freq = 32'hFFFF_FFF0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("wrap", frequency, 32'h0000_00E6);
    check("wrap_tx", tx_active, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("wrap_abort_tx", tx_active, 0);
    run_full(32'hFFFF_FFF0, 1'b0, 1'b0, -1);

    // Asynchronous reset mid-run.
    base_freq = 32'd3000;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (12) step();
    check("pre_rst_tx", tx_active, 1);
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_freq", frequency, 0);
    check("arst_tx", tx_active, 0);
    check("arst_idx", symbol_index, 0);
    check("arst_wr_err", wr_err, 0);
    @(negedge clock);
    reset_n = 1'b1;
    step();
    check("post_rst_tx", tx_active, 0);
    run_full(32'd3000, 1'b0, 1'b0, -1);

    // Randomized symbol sets and base words.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < N; i++) begin
        model[i] = 2'($urandom_range(0, 3));
        write_sym(8'(i), model[i]);
      end
      run_full($urandom, 1'b1, 1'b0, -1);
    end
    check("final_wr_err", wr_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
